sopc_mem_arbiter: RTL and testbench
===================================

SOPC_MEM_ARBITER -- requirements
Module: sopc_mem_arbiter

Interface
REQ-001 Parameter NUM_MASTERS SHALL exist: default 2, number of requesting ports, legal range 2..4.
REQ-002 Parameter DATA_W SHALL exist: default 32, data width, legal values 32 or 64.
REQ-003 Parameter MEM_AW SHALL exist: default 10, memory word-address width.
REQ-004 Parameter MEM_LAT SHALL exist: default 1, memory read latency in cycles, legal range 1..3.
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-007 Port req_i SHALL be an input, NUM_MASTERS bits wide: per-master access request.
REQ-008 Port we_i SHALL be an input, NUM_MASTERS*DATA_W/8 bits wide: per-master byte write enables; all-zero means read.
REQ-009 Port addr_i SHALL be an input, NUM_MASTERS*32 bits wide: per-master byte address.
REQ-010 Port wdata_i SHALL be an input, NUM_MASTERS*DATA_W bits wide: per-master write data.
REQ-011 Port gnt_o SHALL be an output, NUM_MASTERS bits wide: one-hot grant; the access is accepted this cycle.
REQ-012 Port rvalid_o SHALL be an output, NUM_MASTERS bits wide: one-hot read-data-valid pulse.
REQ-013 Port rdata_o SHALL be an output, DATA_W bits wide: shared read data, meaningful only while rvalid_o is nonzero.
REQ-014 Memory-side ports mem_en_o (1 bit), mem_we_o (DATA_W/8 bits), mem_addr_o (MEM_AW bits) and mem_wdata_o (DATA_W bits) SHALL be outputs, and mem_rdata_i (DATA_W bits) SHALL be an input, connecting to a synchronous single-port RAM.
REQ-015 Port conflict_cnt_o SHALL be an output, 16 bits wide, and cnt_clr_i SHALL be an input, 1 bit wide: the contention counter and its synchronous clear.

Function
REQ-016 The block SHALL grant at most one master per cycle; gnt_o is combinational from req_i and the round-robin pointer.
REQ-017 Round-robin: the search SHALL start at (last granted + 1) mod NUM_MASTERS; the pointer updates only on a grant.
REQ-018 A master SHALL hold req_i, we_i, addr_i and wdata_i stable until it sees gnt_o; dropping req_i before grant is legal and discards the request.
REQ-019 On a grant, in the same cycle: mem_en_o=1, mem_we_o=granted we_i, mem_wdata_o=granted wdata_i, mem_addr_o=granted addr_i[log2(DATA_W/8)+MEM_AW-1 : log2(DATA_W/8)]; upper address bits are ignored.
REQ-020 With no grant: mem_en_o=0 and mem_we_o=0; mem_addr_o and mem_wdata_o hold their last value.
REQ-021 A write SHALL complete at grant and produce no rvalid_o.
REQ-022 A read granted in cycle t SHALL assert rvalid_o for the same master in exactly cycle t+MEM_LAT, with rdata_o=mem_rdata_i.
REQ-023 Reads SHALL be fully pipelined: back-to-back grants every cycle; the tag pipeline is a MEM_LAT-deep shift register of {valid, master id}.
REQ-024 A master may receive a new grant while its earlier reads are still in flight; responses return in grant order.
REQ-025 conflict_cnt_o SHALL increment in each cycle where two or more req_i bits are high, saturate at 0xFFFF, and clear on cnt_clr_i; cnt_clr_i takes priority over increment in the same cycle.

Reset
REQ-026 While rst=0, the outputs SHALL be: gnt_o=0, rvalid_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0 and conflict_cnt_o=0.
REQ-027 Reset SHALL set the round-robin pointer to NUM_MASTERS-1, so master 0 wins the first contention.
REQ-028 Reset mid-operation SHALL flush all in-flight read tags; no rvalid_o is issued for reads granted before reset.

Structure
REQ-029 Package sopc_pkg SHALL hold the master-id width function, the MEM_LAT bounds and the default parameter constants.
REQ-030 Sub-module sopc_rr_arb SHALL hold the one-hot grant logic and the pointer; the tag pipeline, address slicing and counter live in the top module.

Verification
REQ-031 Scenario (reset): rst released, no requests -> all outputs 0; 1st grant at contention goes to master 0.
REQ-032 Scenario (contention): NUM_MASTERS=2, both masters read 0x10/0x20 continuously -> grants alternate 0,1,0,1; rvalid alternates MEM_LAT cycles later; conflict_cnt_o increments by 1 per cycle.
REQ-033 Scenario (byte write): master 1 writes we=4'b0010 to 0x0000_0044 -> mem_addr_o=0x011 and mem_we_o=4'b0010 in the same cycle; no rvalid.
REQ-034 Scenario (pipelined reads): MEM_LAT=3, master 0 reads 4 consecutive cycles -> 4 consecutive rvalid_o[0] pulses starting 3 cycles after the first grant, data in order.
REQ-035 Scenario (reset mid-flight): rst asserted 1 cycle after a read grant with MEM_LAT=2 -> no rvalid_o after release.
REQ-036 Scenario (counter): counter forced to 0xFFFF with contention -> it holds 0xFFFF; cnt_clr_i together with contention -> 0.

Source files
------------

// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared constants, the master-id width helper and the read-tag type
// for the SoPC memory arbiter.
package sopc_pkg;

    localparam int unsigned DEF_NUM_MASTERS = 2;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_MEM_AW      = 10;
    localparam int unsigned DEF_MEM_LAT     = 1;

    localparam int unsigned MEM_LAT_MIN     = 1;
    localparam int unsigned MEM_LAT_MAX     = 3;

    // Byte address width of every master port
    localparam int unsigned ADDR_W          = 32;

    // Widest master id needed (up to four masters)
    localparam int unsigned MAX_ID_W        = 2;

    // Width of a master index; a single bit is kept even for two masters
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One stage of the read-response tag pipeline
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/sopc_mem_arbiter_rr_arb.sv
// Round-robin arbiter: one-hot grant from the request vector and the
// last-granted pointer; the pointer advances only when a grant is issued.
module sopc_rr_arb
    import sopc_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ID_W        = id_width(DEF_NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [ID_W-1:0]        gnt_id_o,
    output logic                   gnt_any_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] idx;

    // Search from the master after the last winner; reset forces no grant
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = ID_W'((32'(ptr_q) + i) % NUM_MASTERS);
            if (rst && !gnt_any_o && req_i[idx]) begin
                gnt_any_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
        ptr_d = gnt_any_o ? gnt_id_o : ptr_q;
    end

    // Pointer starts at the last master so master 0 wins the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= ID_W'(NUM_MASTERS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Multi-master arbiter in front of a synchronous single-port RAM:
// round-robin grant, in-order pipelined read return and a saturating
// contention counter.
module sopc_mem_arbiter
    import sopc_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned MEM_AW      = DEF_MEM_AW,
    parameter int unsigned MEM_LAT     = DEF_MEM_LAT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          req_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   wdata_i,
    output logic [NUM_MASTERS-1:0]          gnt_o,
    output logic [NUM_MASTERS-1:0]          rvalid_o,
    output logic [DATA_W-1:0]               rdata_o,
    output logic                            mem_en_o,
    output logic [DATA_W/8-1:0]             mem_we_o,
    output logic [MEM_AW-1:0]               mem_addr_o,
    output logic [DATA_W-1:0]               mem_wdata_o,
    input  logic [DATA_W-1:0]               mem_rdata_i,
    output logic [15:0]                     conflict_cnt_o,
    input  logic                            cnt_clr_i
);

    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned BYTE_OFF = $clog2(BE_W);
    localparam int unsigned ID_W     = id_width(NUM_MASTERS);
    localparam int unsigned NREQ_W   = $clog2(NUM_MASTERS + 1);

    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;

    logic [BE_W-1:0]   sel_we;
    logic [MEM_AW-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [MEM_AW-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    rd_tag_t           tag_d;
    rd_tag_t           tag_q [MEM_LAT];

    logic [NREQ_W-1:0] nreq;
    logic              contention;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;

    // Address bits above the RAM word range are intentionally dropped
    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr_i;

    sopc_rr_arb #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id),
        .gnt_any_o (gnt_any)
    );

    // Select the granted master's access fields
    always_comb begin
        sel_we    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            if (gnt_o[m]) begin
                sel_we    = we_i[m*BE_W +: BE_W];
                sel_addr  = addr_i[m*ADDR_W + BYTE_OFF +: MEM_AW];
                sel_wdata = wdata_i[m*DATA_W +: DATA_W];
            end
        end
    end

    // Memory strobes follow the grant combinationally; address/data hold when idle
    always_comb begin
        mem_en_o    = gnt_any;
        mem_we_o    = gnt_any ? sel_we    : '0;
        mem_addr_o  = gnt_any ? sel_addr  : addr_q;
        mem_wdata_o = gnt_any ? sel_wdata : wdata_q;
    end

    // Remember the last presented address and write data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (gnt_any) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Tag entering the pipeline: only granted reads produce a response
    always_comb begin
        tag_d       = '0;
        tag_d.valid = gnt_any && (sel_we == '0);
        tag_d.id    = MAX_ID_W'(gnt_id);
    end

    // Read tag shift register, MEM_LAT deep; reset drops in-flight reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Decode the oldest tag into the one-hot response strobe and shared data
    always_comb begin
        rvalid_o = '0;
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            rvalid_o[m] = tag_q[MEM_LAT-1].valid &&
                          (tag_q[MEM_LAT-1].id == MAX_ID_W'(m));
        end
        rdata_o = (rvalid_o != '0) ? mem_rdata_i : '0;
    end

    // Contention is two or more raw requests in the same cycle
    always_comb begin
        nreq = '0;
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            nreq = nreq + NREQ_W'(req_i[m]);
        end
        contention = (nreq >= NREQ_W'(2));
    end

    // Saturating contention counter; clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (contention && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Contention counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Scoreboard bench for sopc_mem_arbiter: two masters, 32-bit data,
// three-cycle RAM. Grants and memory strobes are checked as each vector
// is applied; read responses are queued and checked by a monitor.
module tb_sopc_mem_arbiter;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        clr;

    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic [15:0] conflict_cnt_o;

    typedef struct {
        int unsigned due;
        logic [1:0]  mst;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_cnt = '0;
    logic [9:0]  last_addr = '0;
    logic [31:0] last_wdata = '0;

    logic [31:0] mem [1024];
    logic [31:0] rd_pipe [LAT];

    always #5 clk = ~clk;

    sopc_mem_arbiter #(
        .NUM_MASTERS (2),
        .DATA_W      (32),
        .MEM_AW      (10),
        .MEM_LAT     (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .conflict_cnt_o (conflict_cnt_o),
        .cnt_clr_i      (clr)
    );

    // RAM contents: word w holds 0xD000_0000 | w until written
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hD000_0000 | i;
        for (int i = 0; i < int'(LAT); i++) rd_pipe[i] = '0;
    end

    // Synchronous RAM with LAT-cycle read latency and byte enables
    always @(posedge clk) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            rd_pipe[0] <= mem[mem_addr_o];
        end
        for (int k = int'(LAT) - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata_i = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Apply one vector for one cycle, check grant-side outputs, queue any read response
    task automatic step(input logic [1:0] r, input logic [3:0] w0, input logic [3:0] w1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic c, input logic [1:0] eg, input logic [31:0] erd,
                        input string tag);
        logic [31:0] ga;
        logic [31:0] gd;
        logic [3:0]  gw;
        @(negedge clk);
        req = r; we = {w1, w0}; addr = {a1, a0}; wdata = {d1, d0}; clr = c;
        #1;
        chk({tag, " gnt"}, 64'(gnt_o), 64'(eg));
        chk({tag, " cnt"}, 64'(conflict_cnt_o), 64'(exp_cnt));
        if (eg != 2'b00) begin
            ga = eg[1] ? a1 : a0;
            gd = eg[1] ? d1 : d0;
            gw = eg[1] ? w1 : w0;
            chk({tag, " mem_en"},    64'(mem_en_o),    64'(1));
            chk({tag, " mem_we"},    64'(mem_we_o),    64'(gw));
            chk({tag, " mem_addr"},  64'(mem_addr_o),  64'(ga[11:2]));
            chk({tag, " mem_wdata"}, 64'(mem_wdata_o), 64'(gd));
            last_addr  = ga[11:2];
            last_wdata = gd;
            if (gw == 4'b0000) sb.push_back('{cyc + LAT, eg, erd});
        end else begin
            chk({tag, " mem_en"},    64'(mem_en_o),    64'(0));
            chk({tag, " mem_we"},    64'(mem_we_o),    64'(0));
            chk({tag, " mem_addr"},  64'(mem_addr_o),  64'(last_addr));
            chk({tag, " mem_wdata"}, 64'(mem_wdata_o), 64'(last_wdata));
        end
        if (c) exp_cnt = '0;
        else if (r == 2'b11 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            step(2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, "idle");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " gnt"},       64'(gnt_o),          64'(0));
        chk({tag, " rvalid"},    64'(rvalid_o),       64'(0));
        chk({tag, " rdata"},     64'(rdata_o),        64'(0));
        chk({tag, " mem_en"},    64'(mem_en_o),       64'(0));
        chk({tag, " mem_we"},    64'(mem_we_o),       64'(0));
        chk({tag, " mem_addr"},  64'(mem_addr_o),     64'(0));
        chk({tag, " mem_wdata"}, 64'(mem_wdata_o),    64'(0));
        chk({tag, " cnt"},       64'(conflict_cnt_o), 64'(0));
    endtask

    // Response monitor: every rvalid pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing: got no rvalid by cycle %0d expected master %b due %0d",
                         cyc, e.mst, e.due);
            end
            if (rvalid_o != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected: got rvalid %b rdata %h expected none (cycle %0d)",
                             rvalid_o, rdata_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_due",    64'(cyc),      64'(e.due));
                    chk("rvalid_master", 64'(rvalid_o), 64'(e.mst));
                    chk("rdata",         64'(rdata_o),  64'(e.data));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; req = 2'b11; we = '0; addr = '0; wdata = '0; clr = 1'b0;
        #3;
        chk_reset_outputs("reset");
        req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        // Contention: both masters read, grants alternate starting with master 0
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_0004, "cont");
            step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 2'b10, 32'hD000_0008, "cont");
        end
        idle(LAT + 1);

        // Byte write by master 1, then read the merged word back
        step(2'b10, 4'h0, 4'b0010, 32'h0, 32'h0000_0044, 32'h0, 32'h1122_3344, 1'b0, 2'b10, 32'h0, "bwr");
        step(2'b10, 4'h0, 4'h0, 32'h0, 32'h0000_0044, 32'h0, 32'h0, 1'b0, 2'b10, 32'hD000_3311, "rdbk");

        // Back-to-back reads by master 0
        step(2'b01, 4'h0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_0040, "pipe");
        step(2'b01, 4'h0, 4'h0, 32'h104, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_0041, "pipe");
        step(2'b01, 4'h0, 4'h0, 32'h108, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_0042, "pipe");
        step(2'b01, 4'h0, 4'h0, 32'h10C, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_0043, "pipe");

        // Mixed write/read contention after master 0 last won
        step(2'b11, 4'hF, 4'h0, 32'h200, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 2'b10, 32'hD000_0008, "mix");
        step(2'b11, 4'hF, 4'h0, 32'h200, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b0, 2'b01, 32'h0, "mix");
        step(2'b10, 4'h0, 4'h0, 32'h0, 32'h24, 32'h0, 32'h0, 1'b0, 2'b10, 32'hD000_0009, "mix");
        step(2'b01, 4'h0, 4'h0, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hCAFE_F00D, "mix");
        idle(LAT + 1);

        // Counter saturation and clear-over-increment
        @(posedge clk);
        #2;
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFE;
        step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 2'b10, 32'hD000_0008, "sat");
        step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_0004, "sat");
        step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 2'b10, 32'hD000_0008, "sat");
        step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b1, 2'b01, 32'hD000_0004, "clr");
        idle(LAT + 1);

        // Reset one cycle after a read grant: the response is flushed
        step(2'b01, 4'h0, 4'h0, 32'h30, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_000C, "flush");
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0; req = 2'b11; clr = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1; req = 2'b00;
        exp_cnt = '0; last_addr = '0; last_wdata = '0;
        idle(LAT + 1);
        step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 2'b01, 32'hD000_0004, "post");
        step(2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 2'b10, 32'hD000_0008, "post");
        idle(LAT + 2);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
